// File: rtl/conbus_timer_if.sv
// Conbus slave-port bundle for conbus_timer: word address, write data/enable and registered read data.
interface conbus_timer_if;
  logic [13:0] bus_a;
  logic [15:0] bus_di;
  logic        bus_we;
  logic [15:0] bus_do;

  modport master (output bus_a, output bus_di, output bus_we, input bus_do);
  modport slave  (input bus_a, input bus_di, input bus_we, output bus_do);
endinterface

// File: rtl/conbus_timer.sv
// Programmable 16-bit timer/counter on a conbus slave port: prescaler, compare match, one-shot/auto-reload, level irq.
// Optional capture input and CAPTURE/STATUS.CAPT logic are built only when TIMER_CAPTURE_EN is defined.
module conbus_timer #(
  parameter int unsigned PRESC_W       = 16,
  parameter logic [15:0] RESET_COMPARE = 16'hffff
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  conbus_timer_if.slave bus,
`ifdef TIMER_CAPTURE_EN
  input  logic          capture,
`endif
  output logic          irq
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CTRL_W = 3;

  localparam logic [2:0] A_CTRL    = 3'd0;
  localparam logic [2:0] A_COMPARE = 3'd1;
  localparam logic [2:0] A_COUNT   = 3'd2;
  localparam logic [2:0] A_STATUS  = 3'd3;
  localparam logic [2:0] A_PRESC   = 3'd4;
  localparam logic [2:0] A_CAPTURE = 3'd5;

  logic [CTRL_W-1:0]  ctrl_q,    ctrl_d;
  logic [DATA_W-1:0]  compare_q, compare_d;
  logic [DATA_W-1:0]  count_q,   count_d;
  logic               match_q,   match_d;
  logic [PRESC_W-1:0] presc_q,   presc_d;
  logic [PRESC_W-1:0] pcnt_q,    pcnt_d;
  logic [DATA_W-1:0]  bus_do_q,  bus_do_d;
  logic               irq_q,     irq_d;

  logic [2:0] addr;
  logic       wr;
  logic       tick;
  logic       capt_bit;
  logic [DATA_W-1:0] capt_val;

  // Only the low three address bits select a register; the rest alias.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.bus_a[13:3];

  assign addr = bus.bus_a[2:0];
  assign wr   = bus.bus_we;
  assign tick = ctrl_q[0] && (pcnt_q == presc_q);

`ifdef TIMER_CAPTURE_EN
  logic              sync1_q, sync2_q, sync3_q;
  logic              capt_q,  capt_d;
  logic [DATA_W-1:0] capture_q, capture_d;
  logic              capt_rise;

  assign capt_rise = sync2_q && !sync3_q;
  assign capt_bit  = capt_q;
  assign capt_val  = capture_q;

  always_comb begin
    capture_d = capture_q;
    capt_d    = capt_q;
    if (wr && addr == A_STATUS && bus.bus_di[1]) capt_d = 1'b0;
    if (capt_rise) begin
      capture_d = count_q;
      capt_d    = 1'b1;
    end
  end

  // Two-flop synchroniser plus one stage for rising-edge detection.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sync3_q   <= 1'b0;
      capt_q    <= 1'b0;
      capture_q <= '0;
    end else begin
      sync1_q   <= capture;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      capt_q    <= capt_d;
      capture_q <= capture_d;
    end
  end
`else
  assign capt_bit = 1'b0;
  assign capt_val = '0;
`endif

  always_comb begin
    ctrl_d    = ctrl_q;
    compare_d = compare_q;
    count_d   = count_q;
    match_d   = match_q;
    presc_d   = presc_q;
    pcnt_d    = '0;
    bus_do_d  = '0;

    if (ctrl_q[0] && !tick) pcnt_d = pcnt_q + PRESC_W'(1);

    // W1C first so a same-cycle hardware match still wins.
    if (wr && addr == A_STATUS && bus.bus_di[0]) match_d = 1'b0;

    if (tick) begin
      if (count_q == compare_q) begin
        match_d = 1'b1;
        if (ctrl_q[1]) count_d   = '0;
        else           ctrl_d[0] = 1'b0;
      end else begin
        count_d = count_q + DATA_W'(1);
      end
    end

    // Bus writes override the timebase updates above.
    if (wr) begin
      case (addr)
        A_CTRL: begin
          ctrl_d = bus.bus_di[CTRL_W-1:0];
          pcnt_d = '0;
        end
        A_COMPARE: compare_d = bus.bus_di;
        A_COUNT:   count_d   = bus.bus_di;
        A_PRESC: begin
          presc_d = bus.bus_di[PRESC_W-1:0];
          pcnt_d  = '0;
        end
        default: ;
      endcase
    end

    irq_d = match_d & ctrl_d[2];

    case (addr)
      A_CTRL:    bus_do_d = DATA_W'(ctrl_q);
      A_COMPARE: bus_do_d = compare_q;
      A_COUNT:   bus_do_d = count_q;
      A_STATUS:  bus_do_d = DATA_W'({capt_bit, match_q});
      A_PRESC:   bus_do_d = DATA_W'(presc_q);
      A_CAPTURE: bus_do_d = capt_val;
      default:   bus_do_d = '0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      ctrl_q    <= '0;
      compare_q <= RESET_COMPARE;
      count_q   <= '0;
      match_q   <= 1'b0;
      presc_q   <= '0;
      pcnt_q    <= '0;
      bus_do_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      compare_q <= compare_d;
      count_q   <= count_d;
      match_q   <= match_d;
      presc_q   <= presc_d;
      pcnt_q    <= pcnt_d;
      bus_do_q  <= bus_do_d;
      irq_q     <= irq_d;
    end
  end

  assign bus.bus_do = bus_do_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_conbus_timer.sv
// Self-checking bench for conbus_timer: register table plus timing sequences for reload, one-shot and collisions.
module tb_conbus_timer;
  logic sys_clk = 1'b0;
  logic sys_rst;
  logic irq;
`ifdef TIMER_CAPTURE_EN
  logic capture = 1'b0;
`endif

  conbus_timer_if bus();

  conbus_timer dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus),
`ifdef TIMER_CAPTURE_EN
    .capture (capture),
`endif
    .irq     (irq)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        we;
    logic [13:0] a;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;

  vec_t        vt [22];
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_q [$];
  string       name_q [$];

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One bus cycle; the expected read word is queued at drive time and popped once the DUT registers it.
  task automatic xfer(input logic we, input logic [13:0] a, input logic [15:0] d,
                      input logic [15:0] exp, input bit chk, input string nm);
    bus.bus_we = we;
    bus.bus_a  = a;
    bus.bus_di = d;
    if (chk) begin
      exp_q.push_back(exp);
      name_q.push_back(nm);
    end
    @(posedge sys_clk); #1;
    bus.bus_we = 1'b0;
    if (chk) check(name_q.pop_front(), bus.bus_do, exp_q.pop_front());
  endtask

  task automatic wr(input logic [13:0] a, input logic [15:0] d);
    xfer(1'b1, a, d, 16'h0, 1'b0, "");
  endtask

  task automatic rd(input logic [13:0] a, input logic [15:0] exp, input string nm);
    xfer(1'b0, a, 16'h0, exp, 1'b1, nm);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) xfer(1'b0, 14'd2, 16'h0, 16'h0, 1'b0, "");
  endtask

  logic [15:0] mc;
  int          mp;
  logic        mm;

  initial begin
    vt[0]  = '{1'b0, 14'h0001, 16'h0000, 16'hffff};
    vt[1]  = '{1'b0, 14'h0000, 16'h0000, 16'h0000};
    vt[2]  = '{1'b0, 14'h0002, 16'h0000, 16'h0000};
    vt[3]  = '{1'b0, 14'h0003, 16'h0000, 16'h0000};
    vt[4]  = '{1'b0, 14'h0004, 16'h0000, 16'h0000};
    vt[5]  = '{1'b0, 14'h0005, 16'h0000, 16'h0000};
    vt[6]  = '{1'b1, 14'h0001, 16'h1234, 16'hffff};
    vt[7]  = '{1'b1, 14'h3ffd, 16'h00ab, 16'h0000};
    vt[8]  = '{1'b0, 14'h0001, 16'h0000, 16'h1234};
    vt[9]  = '{1'b0, 14'h0000, 16'h0000, 16'h0000};
    vt[10] = '{1'b0, 14'h0005, 16'h0000, 16'h0000};
    vt[11] = '{1'b0, 14'h3ff9, 16'h0000, 16'h1234};
    vt[12] = '{1'b1, 14'h0006, 16'hbeef, 16'h0000};
    vt[13] = '{1'b0, 14'h0006, 16'h0000, 16'h0000};
    vt[14] = '{1'b1, 14'h0000, 16'hfff8, 16'h0000};
    vt[15] = '{1'b0, 14'h0000, 16'h0000, 16'h0000};
    vt[16] = '{1'b1, 14'h0004, 16'h00ff, 16'h0000};
    vt[17] = '{1'b0, 14'h0004, 16'h0000, 16'h00ff};
    vt[18] = '{1'b1, 14'h0002, 16'h7777, 16'h0000};
    vt[19] = '{1'b0, 14'h0002, 16'h0000, 16'h7777};
    vt[20] = '{1'b0, 14'h0002, 16'h0000, 16'h7777};
    vt[21] = '{1'b1, 14'h0004, 16'h0000, 16'h00ff};

    bus.bus_a  = '0;
    bus.bus_di = '0;
    bus.bus_we = 1'b0;
    sys_rst    = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    check("rst_bus_do", bus.bus_do, 16'h0);
    check("rst_irq", 16'(irq), 16'h0);
    sys_rst = 1'b1;

    for (int i = 0; i < 22; i++)
      xfer(vt[i].we, vt[i].a, vt[i].d, vt[i].exp, 1'b1, $sformatf("vec%0d", i));

    // Auto-reload: COMPARE=3, PRESC=1, EN|AR|IE; count and irq tracked by a cycle model.
    wr(14'd2, 16'h0);
    wr(14'd3, 16'h1);
    wr(14'd1, 16'h3);
    wr(14'd4, 16'h1);
    wr(14'd0, 16'h7);
    mc = 16'h0; mp = 0; mm = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      xfer(1'b0, 14'd2, 16'h0, mc, 1'b1, $sformatf("ar_count_c%0d", k));
      if (mp == 1) begin
        mp = 0;
        if (mc == 16'd3) begin mc = 16'h0; mm = 1'b1; end
        else mc = mc + 16'd1;
      end else mp++;
      check($sformatf("ar_irq_c%0d", k), 16'(irq), 16'(mm));
    end
    xfer(1'b1, 14'd3, 16'h1, 16'h1, 1'b1, "ar_status_set");
    check("ar_irq_cleared", 16'(irq), 16'h0);
    rd(14'd3, 16'h0, "ar_status_cleared");
    wr(14'd0, 16'h0);

    // One-shot: COMPARE=5, PRESC=0, EN only.
    wr(14'd2, 16'h0);
    wr(14'd3, 16'h1);
    wr(14'd4, 16'h0);
    wr(14'd1, 16'h5);
    wr(14'd0, 16'h1);
    for (int k = 0; k < 12; k++) begin
      idle(1);
      check($sformatf("os_irq_c%0d", k), 16'(irq), 16'h0);
    end
    rd(14'd2, 16'h5, "os_count_stop");
    rd(14'd3, 16'h1, "os_match");
    rd(14'd0, 16'h0, "os_ctrl_en_clr");
    check("os_irq_low", 16'(irq), 16'h0);

    // CTRL write on the one-shot match edge keeps the written EN.
    wr(14'd2, 16'h0);
    wr(14'd3, 16'h1);
    wr(14'd1, 16'h2);
    wr(14'd0, 16'h1);
    idle(2);
    wr(14'd0, 16'h5);
    rd(14'd0, 16'h5, "ctrl_beats_hw");
    check("ctrl_irq", 16'(irq), 16'h1);
    rd(14'd0, 16'h4, "ctrl_second_oneshot");
    wr(14'd0, 16'h0);
    wr(14'd3, 16'h1);

    // COUNT write on a tick cycle takes priority over the increment.
    wr(14'd2, 16'h0);
    wr(14'd1, 16'hffff);
    wr(14'd4, 16'h0);
    wr(14'd0, 16'h1);
    idle(3);
    xfer(1'b1, 14'd2, 16'h0100, 16'h0003, 1'b1, "coll_count_old");
    rd(14'd2, 16'h0100, "coll_count_wr");
    rd(14'd2, 16'h0101, "coll_count_inc");
    wr(14'd0, 16'h0);

    // W1C on the match edge loses; a later W1C clears.
    wr(14'd2, 16'h0);
    wr(14'd3, 16'h1);
    wr(14'd1, 16'h3);
    wr(14'd4, 16'h0);
    wr(14'd0, 16'h3);
    idle(3);
    xfer(1'b1, 14'd3, 16'h1, 16'h0, 1'b1, "w1c_pre");
    rd(14'd3, 16'h1, "w1c_match_wins");
    wr(14'd3, 16'h1);
    rd(14'd3, 16'h0, "w1c_clears");
    wr(14'd0, 16'h0);

`ifdef TIMER_CAPTURE_EN
    wr(14'd3, 16'h3);
    wr(14'd1, 16'hffff);
    wr(14'd0, 16'h1);
    capture = 1'b1;
    wr(14'd2, 16'h0010);
    capture = 1'b0;
    idle(4);
    rd(14'd5, 16'h0011, "capt_value");
    rd(14'd3, 16'h0002, "capt_status");
    wr(14'd0, 16'h0);
`endif

    // Asynchronous reset while counting.
    wr(14'd4, 16'h0);
    wr(14'd1, 16'hffff);
    wr(14'd0, 16'h7);
    idle(5);
    sys_rst = 1'b0;
    #1;
    check("midrst_bus_do", bus.bus_do, 16'h0);
    check("midrst_irq", 16'(irq), 16'h0);
    @(posedge sys_clk); #1;
    sys_rst = 1'b1;
    rd(14'd2, 16'h0, "midrst_count");
    rd(14'd2, 16'h0, "midrst_count_hold");
    rd(14'd0, 16'h0, "midrst_ctrl");
    rd(14'd1, 16'hffff, "midrst_compare");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
